// File: rtl/fetch_queue.sv
// Instruction fetch queue: issues in-order fetches under a credit rule and buffers {pc,instr}.
// Define FETCH_QUEUE_BYPASS_EN to forward a response straight to the deq outputs when the queue is empty.
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  output logic                     imem_req_o,
  output logic [31:0]              imem_addr_o,
  input  logic                     imem_gnt_i,
  input  logic                     imem_rvalid_i,
  input  logic [31:0]              imem_rdata_i,
  input  logic                     redirect_i,
  input  logic [31:0]              redirect_pc_i,
  input  logic                     deq_ready_i,
  output logic                     deq_valid_o,
  output logic [31:0]              deq_pc_o,
  output logic [31:0]              deq_instr_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW:0]   DEPTH_X = (CW+1)'(DEPTH);

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   resp_pc_q, resp_pc_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] outst_q, outst_d;
  logic [CW-1:0] drop_q, drop_d;

  logic [31:0]   fifo_pc_q    [DEPTH];
  logic [31:0]   fifo_instr_q [DEPTH];

  logic [CW:0]   credit_used;
  logic          grant;
  logic          byp;
  logic          pop;
  logic          rsp_drop;
  logic          rsp_keep;
  logic          enq;

  // Live (non-discarded) in-flight responses plus queued entries must fit in the queue.
  always_comb begin
    credit_used = {1'b0, count_q} + {1'b0, outst_q} - {1'b0, drop_q};
    imem_req_o  = !redirect_i && (outst_q < DEPTH_C) && (credit_used < DEPTH_X);
    grant       = imem_req_o && imem_gnt_i;
`ifdef FETCH_QUEUE_BYPASS_EN
    byp         = (count_q == '0) && (drop_q == '0) && imem_rvalid_i && !redirect_i;
`else
    byp         = 1'b0;
`endif
    deq_valid_o = !redirect_i && ((count_q != '0) || byp);
    deq_pc_o    = byp ? resp_pc_q    : fifo_pc_q[rd_ptr_q];
    deq_instr_o = byp ? imem_rdata_i : fifo_instr_q[rd_ptr_q];
    pop         = deq_valid_o && deq_ready_i && (count_q != '0);
    rsp_drop    = imem_rvalid_i && (drop_q != '0);
    rsp_keep    = imem_rvalid_i && (drop_q == '0) && !redirect_i;
    enq         = rsp_keep && !(byp && deq_ready_i);
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    outst_d    = outst_q;
    drop_d     = drop_q;
    if (redirect_i) begin
      // Everything still in flight belongs to the old path, minus a response landing now.
      fetch_pc_d = redirect_pc_i;
      resp_pc_d  = redirect_pc_i;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      outst_d    = outst_q - CW'(imem_rvalid_i);
      drop_d     = outst_q - CW'(imem_rvalid_i);
    end else begin
      if (grant)    fetch_pc_d = fetch_pc_q + 32'd4;
      if (rsp_keep) resp_pc_d  = resp_pc_q + 32'd4;
      if (enq)      wr_ptr_d   = wr_ptr_q + PW'(1);
      if (pop)      rd_ptr_d   = rd_ptr_q + PW'(1);
      if (rsp_drop) drop_d     = drop_q - CW'(1);
      count_d = count_q + CW'(enq) - CW'(pop);
      outst_d = outst_q + CW'(grant) - CW'(imem_rvalid_i);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      outst_q    <= '0;
      drop_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
    end
  end

  // Storage is data only; validity is tracked by count and the pointers.
  always_ff @(posedge clk_i) begin
    if (enq) begin
      fifo_pc_q[wr_ptr_q]    <= resp_pc_q;
      fifo_instr_q[wr_ptr_q] <= imem_rdata_i;
    end
  end

  assign imem_addr_o = fetch_pc_q;
  assign count_o     = count_q;

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter DEPTH, 4, queue entries; SHALL be a power of two in 2..16.
REQ-002 Parameter RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-003 clk_i  in  1  single clock; all state updates on rising edge.
REQ-004 rst_i  in  1  reset, asynchronous, active-high.
REQ-005 imem_req_o  out  1  fetch request to instruction memory.
REQ-006 imem_addr_o  out  32  fetch address; equals fetch_pc.
REQ-007 imem_gnt_i  in  1  request accepted this cycle; meaningful only with imem_req_o=1.
REQ-008 imem_rvalid_i  in  1  response valid; responses return in request order, at least 1 cycle after grant.
REQ-009 imem_rdata_i  in  32  returned instruction word.
REQ-010 redirect_i  in  1  taken branch from MEM stage; flush and restart.
REQ-011 redirect_pc_i  in  32  restart address, sampled when redirect_i=1.
REQ-012 deq_ready_i  in  1  IF/ID register accepts (not stalled).
REQ-013 deq_valid_o  out  1  head entry valid.
REQ-014 deq_pc_o  out  32  PC of head entry.
REQ-015 deq_instr_o  out  32  instruction of head entry.
REQ-016 count_o  out  clog2(DEPTH)+1  current occupancy.

Function
REQ-017 State: fetch_pc, resp_pc, circular FIFO of {pc,instr} with rd/wr pointers, count, outstanding, drop_cnt; counters clog2(DEPTH)+1 bits.
REQ-018 imem_req_o = !redirect_i && outstanding<DEPTH && count+(outstanding-drop_cnt)<DEPTH (credit rule; queue can never overflow).
REQ-019 On req&&gnt: fetch_pc+=4 (mod 2^32 wrap), outstanding+=1.
REQ-020 On rvalid with drop_cnt>0: response discarded, drop_cnt-=1, outstanding-=1.
REQ-021 On rvalid with drop_cnt=0: write {resp_pc, rdata} at wr pointer, resp_pc+=4, outstanding-=1; deq_valid_o=1 no earlier than next cycle.
REQ-022 deq_valid_o = (count!=0) && !redirect_i; head entry popped when deq_valid_o && deq_ready_i.
REQ-023 Simultaneous enqueue and dequeue: count unchanged; full queue with deq_ready_i=1 frees a slot the same cycle for credit purposes only next cycle.
REQ-024 Empty queue with deq_ready_i=1: no pop, count stays 0, no underflow.
REQ-025 Redirect: count<=0, pointers reset, fetch_pc<=resp_pc<=redirect_pc_i, drop_cnt<=outstanding minus any response discarded in the same cycle; a response arriving that cycle is discarded.
REQ-026 Redirect while drop_cnt>0 (back-to-back): drop_cnt covers all outstanding; no old-path instruction ever dequeued.
REQ-027 Head outputs hold stable while deq_valid_o=1 and deq_ready_i=0.

Reset
REQ-028 rst_i=1: fetch_pc=resp_pc=RESET_PC, count=outstanding=drop_cnt=0, pointers 0, deq_valid_o=0, count_o=0; FIFO storage not reset.
REQ-029 Reset mid-operation: in-flight responses after deassert are not covered; memory SHALL be reset together.
REQ-030 First cycle after deassert: imem_req_o=1, imem_addr_o=RESET_PC.

Configuration
REQ-031 Macro FETCH_QUEUE_BYPASS_EN defined: when count=0, drop_cnt=0, rvalid=1, redirect_i=0, response appears combinationally on deq outputs with deq_valid_o=1; if deq_ready_i=1 it is consumed without enqueue.
REQ-032 Macro undefined: no bypass; minimum response-to-deq latency is 1 cycle per REQ-021.

Verification
REQ-033 Reset, gnt=1 every cycle, rvalid 1 cycle after gnt, deq_ready=1 -> deq PCs 0,4,8,... consecutive, count_o<=1.
REQ-034 DEPTH=4, deq_ready=0 -> exactly 4 grants, count_o=4, imem_req_o=0 thereafter; deq_ready=1 one cycle -> one new request.
REQ-035 Redirect to 32'h100 with 3 outstanding, 2 queued -> 3 responses discarded, count_o=0, next deq_pc_o=32'h100.
REQ-036 Redirect in same cycle as rvalid and deq_ready -> deq_valid_o=0 that cycle, response dropped, nothing old dequeued.
REQ-037 Redirect to 32'hFFFF_FFFC -> deq PCs FFFF_FFFC then 0000_0000 (wrap).
REQ-038 BYPASS_EN, empty queue, rvalid=1, instr 32'h2001_0005, deq_ready=1 -> deq_valid_o=1 same cycle, count_o stays 0.
